// File: rtl/inst_fetch_unit_if.sv
// Instruction bus between the fetch stage (master) and the instruction cache (slave).
// Latency: none, this is only a bundle of wires.
// Backpressure: the cache holds the master with stall and blocks issue with ready=0.
interface cpu_ibus_if;
    logic [31:0] addr;
    logic        read;
    logic        flush_1;
    logic        flush_2;
    logic        flush_3;
    logic        stall;
    logic        ready;
    logic [31:0] rddata;
    logic        rddata_vld;

    modport master (
        output addr, read, flush_1, flush_2, flush_3,
        input  stall, ready, rddata, rddata_vld
    );

    modport slave (
        input  addr, read, flush_1, flush_2, flush_3,
        output stall, ready, rddata, rddata_vld
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: issues sequential PCs to the icache, pairs returning data with its PC, queues pairs for decode.
// Latency: request accepted in cycle T returns in T+3, and the entry is visible at the queue head in T+4.
// Backpressure: credit based, so issue stops once queued plus in-flight entries reach QUEUE_DEPTH; the cache stall holds issue.
//
// Ports: clk/rst (sync, active high); redirect_valid/redirect_pc restart fetch and flush the cache;
// ibus is the cache request/response bus; inst_* is the valid/ready queue head presented to decode.
module inst_fetch_unit #(
    parameter logic [31:0] BOOT_PC     = 32'hbfc0_0000,
    parameter int          QUEUE_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    cpu_ibus_if.master        ibus,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_pc,
    output logic [31:0]       inst,
    output logic              inst_adel
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        adel;
    } qent_t;

    logic [31:0]   pc_q, pc_d;
    logic          s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
    logic [31:0]   s1_pc_q, s1_pc_d, s2_pc_q, s2_pc_d, s3_pc_q, s3_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          adel_done_q, adel_done_d;
    qent_t         mem_q [QUEUE_DEPTH];

    logic          misaligned;
    logic          credit_ok;
    logic          full;
    logic          accept;
    logic          adel_push;
    logic          push;
    logic          pop;
    logic [CW:0]   reserved;
    qent_t         push_ent;
    qent_t         head;

    // Every accepted request already owns a queue slot: in-flight requests count as reserved entries.
    assign reserved   = {1'b0, count_q}
                      + {{CW{1'b0}}, s1_vld_q}
                      + {{CW{1'b0}}, s2_vld_q}
                      + {{CW{1'b0}}, s3_vld_q};
    assign credit_ok  = reserved < (CW+1)'(QUEUE_DEPTH);
    assign full       = count_q == CW'(QUEUE_DEPTH);
    assign misaligned = pc_q[1:0] != 2'b00;

    assign ibus.addr    = pc_q;
    assign ibus.read    = ibus.ready & ~rst & ~redirect_valid & ~misaligned & credit_ok;
    assign ibus.flush_1 = redirect_valid;
    assign ibus.flush_2 = redirect_valid;
    assign ibus.flush_3 = redirect_valid;

    assign accept = ibus.read & ~ibus.stall;

    // A misaligned PC turns into a single exception entry once older fetches have drained,
    // which keeps the queue in program order.
    assign adel_push = misaligned & ~adel_done_q & ~s1_vld_q & ~s2_vld_q & ~s3_vld_q & ~full;

    // A redirect drops any data returning in the same cycle.
    assign push = ~redirect_valid & (ibus.rddata_vld | adel_push);
    assign pop  = inst_valid & inst_ready;

    always_comb begin
        push_ent = '0;
        if (ibus.rddata_vld) begin
            push_ent.pc   = s3_pc_q;
            push_ent.word = ibus.rddata;
            push_ent.adel = 1'b0;
        end else begin
            push_ent.pc   = pc_q;
            push_ent.word = 32'd0;
            push_ent.adel = 1'b1;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign inst_valid = count_q != '0;
    assign inst_pc    = head.pc;
    assign inst       = head.adel ? 32'd0 : head.word;
    assign inst_adel  = head.adel;

    always_comb begin
        pc_d        = pc_q;
        s1_vld_d    = s1_vld_q;
        s1_pc_d     = s1_pc_q;
        s2_vld_d    = s2_vld_q;
        s2_pc_d     = s2_pc_q;
        s3_vld_d    = s3_vld_q;
        s3_pc_d     = s3_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        adel_done_d = adel_done_q;
        if (redirect_valid) begin
            // Redirect wins over acceptance, return and pop in the same cycle.
            pc_d        = redirect_pc;
            s1_vld_d    = 1'b0;
            s2_vld_d    = 1'b0;
            s3_vld_d    = 1'b0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            adel_done_d = 1'b0;
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            // Shadow of the cache pipeline: stage 1 holds under stall, stage 2 gets a bubble.
            if (!ibus.stall) begin
                s1_vld_d = accept;
                s1_pc_d  = pc_q;
            end
            s2_vld_d = s1_vld_q & ~ibus.stall;
            s2_pc_d  = s1_pc_q;
            s3_vld_d = s2_vld_q;
            s3_pc_d  = s2_pc_q;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (adel_push) begin
                adel_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= BOOT_PC;
            s1_vld_q    <= 1'b0;
            s1_pc_q     <= '0;
            s2_vld_q    <= 1'b0;
            s2_pc_q     <= '0;
            s3_vld_q    <= 1'b0;
            s3_pc_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            adel_done_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            s1_vld_q    <= s1_vld_d;
            s1_pc_q     <= s1_pc_d;
            s2_vld_q    <= s2_vld_d;
            s2_pc_q     <= s2_pc_d;
            s3_vld_q    <= s3_vld_d;
            s3_pc_q     <= s3_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            adel_done_q <= adel_done_d;
        end
    end

    // Queue storage needs no reset; count_q qualifies every entry.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end

    // The credit rule makes a push into a full queue unreachable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
    localparam logic [31:0] BOOT = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_adel;

    cpu_ibus_if ibus_if ();

    inst_fetch_unit #(.BOOT_PC(BOOT), .QUEUE_DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ibus           (ibus_if),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst           (inst),
        .inst_adel      (inst_adel)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_pop = 0;
    int n0;

    // Cache pipeline model and expected streams.
    logic        c1v, c2v, c3v;
    logic [31:0] c1a, c2a, c3a;
    logic [31:0] exp_issue;
    logic [31:0] exp_pc;

    // Per-cycle snapshot taken at the falling edge.
    logic        s_read, s_f1, s_f2, s_f3, s_iv, s_adel, s_rvld, s_all3, s_any;
    logic [31:0] s_addr, s_ipc, s_inst, s_cnt;

    function automatic logic [31:0] cache_word(input logic [31:0] a);
        return a ^ 32'hdead_beef;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic acc;
        @(negedge clk);
        s_read = ibus_if.read;
        s_addr = ibus_if.addr;
        s_f1   = ibus_if.flush_1;
        s_f2   = ibus_if.flush_2;
        s_f3   = ibus_if.flush_3;
        s_rvld = ibus_if.rddata_vld;
        s_iv   = inst_valid;
        s_ipc  = inst_pc;
        s_inst = inst;
        s_adel = inst_adel;
        s_cnt  = 32'(dut.count_q);
        s_all3 = dut.s1_vld_q & dut.s2_vld_q & dut.s3_vld_q;
        s_any  = dut.s1_vld_q | dut.s2_vld_q | dut.s3_vld_q;
        check("addr", s_addr, exp_issue);
        check("flush_1", 32'(s_f1), 32'(redirect_valid));
        check("flush_2", 32'(s_f2), 32'(redirect_valid));
        check("flush_3", 32'(s_f3), 32'(redirect_valid));
        check("s3_vld_vs_rddata_vld", 32'(dut.s3_vld_q), 32'(s_rvld));
        if (s_addr[1:0] != 2'b00) check("read_misaligned", 32'(s_read), 32'd0);
        if (s_iv && inst_ready && !redirect_valid && !rst) begin
            check("inst_pc", s_ipc, exp_pc);
            check("inst_adel", 32'(s_adel), 32'(exp_pc[1:0] != 2'b00));
            check("inst", s_inst, (exp_pc[1:0] != 2'b00) ? 32'd0 : cache_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        acc = s_read & ~ibus_if.stall;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_issue = BOOT; exp_pc = BOOT;
            c1v = 1'b0; c2v = 1'b0; c3v = 1'b0;
        end else if (redirect_valid) begin
            exp_issue = redirect_pc; exp_pc = redirect_pc;
            c1v = 1'b0; c2v = 1'b0; c3v = 1'b0;
        end else begin
            if (acc) exp_issue = exp_issue + 32'd4;
            c3v = c2v; c3a = c2a;
            c2v = c1v & ~ibus_if.stall; c2a = c1a;
            if (!ibus_if.stall) begin
                c1v = acc; c1a = s_addr;
            end
        end
        ibus_if.rddata_vld = c3v;
        ibus_if.rddata     = c3v ? cache_word(c3a) : 32'd0;
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b1;
        ibus_if.ready = 1'b1; ibus_if.stall = 1'b0;
        ibus_if.rddata = 32'd0; ibus_if.rddata_vld = 1'b0;
        c1v = 1'b0; c2v = 1'b0; c3v = 1'b0; c1a = '0; c2a = '0; c3a = '0;
        exp_issue = BOOT; exp_pc = BOOT;

        // Reset
        repeat (3) cyc();
        check("rst_read", 32'(s_read), 32'd0);
        check("rst_inst_valid", 32'(s_iv), 32'd0);
        check("rst_count", s_cnt, 32'd0);

        // Boot: first request in T, first entry at T+4, then one per cycle
        rst = 1'b0;
        cyc();
        check("boot_read", 32'(s_read), 32'd1);
        check("boot_addr", s_addr, BOOT);
        repeat (3) cyc();
        check("boot_t3_empty", 32'(s_iv), 32'd0);
        cyc();
        check("boot_t4_valid", 32'(s_iv), 32'd1);
        check("boot_t4_pc", s_ipc, BOOT);
        repeat (6) cyc();
        check("boot_pops", 32'(n_pop), 32'd7);

        // Stall for 5 cycles: request held, address constant
        ibus_if.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_read", 32'(s_read), 32'd1);
        end
        ibus_if.stall = 1'b0;
        n0 = n_pop;
        repeat (10) cyc();
        check("stall_resume", 32'(n_pop - n0 > 0), 32'd1);

        // Backpressure: queue fills to exactly 8 with nothing in flight
        inst_ready = 1'b0;
        repeat (15) cyc();
        check("bp_read_off", 32'(s_read), 32'd0);
        check("bp_count", s_cnt, 32'd8);
        check("bp_inflight", 32'(s_any), 32'd0);
        inst_ready = 1'b1;
        cyc();
        check("bp_full_read", 32'(s_read), 32'd0);
        cyc();
        check("bp_resume_read", 32'(s_read), 32'd1);
        repeat (8) cyc();

        // Redirect with three in flight
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
        cyc();
        check("redir_inflight3", 32'(s_all3), 32'd1);
        check("redir_read", 32'(s_read), 32'd0);
        redirect_valid = 1'b0;
        cyc();
        check("redir_next_addr", s_addr, 32'h8000_1000);
        check("redir_next_read", 32'(s_read), 32'd1);
        check("redir_q_empty", 32'(s_iv), 32'd0);
        repeat (3) cyc();
        cyc();
        check("redir_first_valid", 32'(s_iv), 32'd1);
        check("redir_first_pc", s_ipc, 32'h8000_1000);
        repeat (4) cyc();

        // Redirect, returning data and pop all in one cycle
        redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
        cyc();
        check("same_rddata_vld", 32'(s_rvld), 32'd1);
        check("same_inst_valid", 32'(s_iv), 32'd1);
        redirect_valid = 1'b0;
        cyc();
        check("same_q_empty", 32'(s_iv), 32'd0);
        check("same_count", s_cnt, 32'd0);
        check("same_addr", s_addr, 32'h8000_2000);
        repeat (6) cyc();

        // Misaligned target: single exception entry, then idle
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        check("mis_read", 32'(s_read), 32'd0);
        check("mis_addr", s_addr, 32'h8000_0002);
        cyc();
        check("mis_entry_valid", 32'(s_iv), 32'd1);
        check("mis_entry_pc", s_ipc, 32'h8000_0002);
        check("mis_entry_inst", s_inst, 32'd0);
        check("mis_entry_adel", 32'(s_adel), 32'd1);
        repeat (4) cyc();
        check("mis_idle_valid", 32'(s_iv), 32'd0);
        check("mis_idle_read", 32'(s_read), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        check("mis_resume_read", 32'(s_read), 32'd1);
        check("mis_resume_addr", s_addr, 32'h8000_0000);
        repeat (6) cyc();

        // Cache not ready: no issue, pc holds
        ibus_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("nrdy_read", 32'(s_read), 32'd0);
        end
        ibus_if.ready = 1'b1;
        repeat (6) cyc();

        // Reset mid-stream discards everything
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        check("mrst_valid", 32'(s_iv), 32'd0);
        check("mrst_addr", s_addr, BOOT);
        check("mrst_count", s_cnt, 32'd0);
        repeat (6) cyc();
        check("mrst_stream", 32'(s_iv), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
